program_encoder: RTL

Encodes RV32I instructions from decoded fields into 32-bit machine words and writes them sequentially into instruction memory. It holds the CPU core in reset until a complete program is loaded. It is the inverse of the control/decode path: fields in, instruction words out. It sits between a test/host source and the instruction memory's write port.

---
 rtl/program_encoder.sv | 98 +++++++++
 1 files changed

// File: rtl/program_encoder.sv
// Encodes RV32I instruction fields into machine words and streams them into
// instruction memory. The core is held in reset until the program has loaded.
module program_encoder #(
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    input  logic              last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic [ADDR_W:0]   word_count,
    output logic              error
);

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_ERROR} state_t;

    state_t      state, state_d;
    logic [31:0] word;
    logic        legal;
    logic        accept;
    logic        full;

    assign in_ready  = (state == S_LOAD);
    assign cpu_rst_n = (state == S_RUN);
    assign error     = (state == S_ERROR);
    assign accept    = in_valid & in_ready;
    assign full      = (word_count == (ADDR_W+1)'(IMEM_DEPTH - 1));

    // Field packing; branch/jump targets must be 2-byte aligned.
    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (fmt)
            3'd0: word = {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, op};
            3'd1: begin
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    word = {1'b0, funct7b5, 5'b0, imm[4:0], rs1, funct3, rd, op};
                else
                    word = {imm[11:0], rs1, funct3, rd, op};
            end
            3'd2: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
            3'd3: begin
                word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
                legal = ~imm[0];
            end
            3'd4: word = {imm[31:12], rd, op};
            3'd5: begin
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                legal = ~imm[0];
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state;
        if (accept) begin
            if (!legal)
                state_d = S_ERROR;
            else if (last)
                state_d = S_RUN;
            else if (full)
                state_d = S_ERROR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_LOAD;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_count <= '0;
        end else begin
            state   <= state_d;
            imem_we <= accept & legal;
            if (accept && legal) begin
                imem_addr  <= word_count[ADDR_W-1:0];
                imem_wdata <= word;
                word_count <= word_count + 1'b1;
            end
        end
    end

endmodule
